mux2x1_core: RTL and testbench
==============================

Name: mux2x1_core

Overview:
- Parameterised 2-to-1 data selector: a zero-latency combinational output plus a one-cycle registered copy with a valid flag.
- Used as a leaf datapath primitive wherever a single control bit steers one of two equal-width operands downstream.
- The combinational path serves glue logic. The registered path serves timing-critical consumers.

Parameters:
- WIDTH, 1, bit width of a, b, y and y_q; legal range 1..64.
- RESET_VAL, 0, value loaded into y_q on reset; WIDTH bits, zero-extended/truncated to WIDTH.

Ports:
- clk  input  1  single system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand selected when sel = 0.
- b  input  WIDTH  operand selected when sel = 1.
- sel  input  1  select: 0 -> a, 1 -> b.
- in_valid  input  1  qualifies a/b/sel for the registered path.
- y  output  WIDTH  combinational mux result.
- y_q  output  WIDTH  registered mux result.
- y_q_valid  output  1  high when y_q holds a result captured with in_valid = 1.

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Combinational path:
  - y = b when sel = 1, else y = a. Applies bitwise across all WIDTH bits.
  - Zero latency; y is independent of clk, rst and in_valid.
  - Any sel value other than a clean 1 (including X/Z in simulation) selects a. Implement as an explicit equality against 1, not a ternary on sel.
- Registered path, evaluated on each rising clk edge:
  - If rst = 1: y_q <= RESET_VAL and y_q_valid <= 0. Reset has priority over in_valid.
  - Else if in_valid = 1: y_q <= (sel ? b : a) and y_q_valid <= 1.
  - Else: y_q holds its previous value and y_q_valid <= 0.
- Latency: y_q and y_q_valid reflect inputs sampled at edge N and are visible after edge N. This is one cycle of latency.
- Throughput: one result per cycle; no backpressure; no ready signal.
- Reset asserted mid-stream discards the in-flight capture at that edge. The first valid output after reset deasserts requires in_valid = 1 on a later edge.
- Before the first clk edge, y_q is undefined. Only the combinational y is guaranteed without a clock.
- No internal state beyond y_q and y_q_valid. No state machine.

Decomposition:
- Shared package mux_pkg holds:
  - constant MUX_DEFAULT_WIDTH = 1;
  - localparam SEL_A = 1'b0 and SEL_B = 1'b1;
  - a function mux_sel(a, b, sel) used by both paths, so the selection rule is defined once.
- One natural sub-module, mux2x1_oreg: WIDTH-wide output register with load enable, synchronous reset value and valid flag. The top instantiates it once, after the combinational select.

Test Plan:
- Combinational truth table, WIDTH = 1, no clock, 10 ns per step:
  - (a, b, sel) = (0,0,0) -> y = 0
  - (1,0,0) -> y = 1
  - (0,1,1) -> y = 1
  - (1,1,0) -> y = 1
  - (1,1,1) -> y = 1
  - (1,0,1) -> y = 0
- Exhaustive WIDTH = 8 sweep: a = 8'hA5, b = 8'h3C.
  - sel = 0 -> y = 8'hA5
  - sel = 1 -> y = 8'h3C
  - sel = X -> y = 8'hA5
- Registered latency with in_valid = 1:
  - Edge 1: sel = 1, b = 8'h3C; edge 2: sel = 0, a = 8'hA5.
  - After edge 1: y_q = 8'h3C, y_q_valid = 1.
  - After edge 2: y_q = 8'hA5.
- Hold behaviour: after a valid capture of 8'h3C, drive in_valid = 0 and change a/b/sel for 3 cycles.
  - y_q stays 8'h3C; y_q_valid = 0; y tracks the inputs live.
- Reset: assert rst with in_valid = 1 and sel = 1, b = 8'hFF.
  - After the edge: y_q = RESET_VAL (0), y_q_valid = 0.
  - Deassert rst; the next valid edge captures normally.
- Parameter check: WIDTH = 64 with a = all-ones, b = 0, toggling sel every cycle.
  - y and y_q alternate all-ones/zero; y_q lags y by exactly one cycle.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the 2-to-1 selector family.
//
// Contents:
//   MUX_DEFAULT_WIDTH - default operand width for mux instances
//   MUX_MAX_WIDTH     - widest operand the selection helper carries
//   SEL_A / SEL_B     - select encodings (0 -> a, 1 -> b)
//   mux_sel()         - the one place the selection rule lives; both the
//                       combinational and registered paths use its result
package mux_pkg;

  localparam int MUX_DEFAULT_WIDTH = 1;
  localparam int MUX_MAX_WIDTH     = 64;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Operands travel at the maximum width; callers zero-extend on the way in
  // and truncate on the way out. The equality test (rather than using sel as
  // a ternary condition) makes any sel that is not a clean 1, including X/Z
  // in simulation, fall through to operand a.
  function automatic logic [MUX_MAX_WIDTH-1:0] mux_sel(
    input logic [MUX_MAX_WIDTH-1:0] a,
    input logic [MUX_MAX_WIDTH-1:0] b,
    input logic                     sel
  );
    logic [MUX_MAX_WIDTH-1:0] r;
    r = a;
    if (sel == SEL_B) begin
      r = b;
    end
    return r;
  endfunction

endpackage : mux_pkg

// File: rtl/mux2x1_oreg.sv
// Output register with load enable, synchronous reset value and valid flag.
//
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset; wins over load
//   load     - capture d this edge and raise q_valid
//   d        - WIDTH-bit data to capture
//   q        - registered data; holds when load is low
//   q_valid  - high for exactly the cycle after a load edge
//
// Handshake: load acts as a valid-only qualifier. There is no ready; every
// edge with load = 1 is accepted and the result is visible after that edge.
module mux2x1_oreg
  import mux_pkg::*;
#(
  parameter int                       WIDTH     = MUX_DEFAULT_WIDTH,
  parameter logic [MUX_MAX_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= RST_Q;
      q_valid <= 1'b0;
    end else if (load) begin
      q       <= d;
      q_valid <= 1'b1;
    end else begin
      // Data holds its last capture; the flag only marks fresh results.
      q_valid <= 1'b0;
    end
  end

endmodule : mux2x1_oreg

// File: rtl/mux2x1_core.sv
// Parameterised 2-to-1 data selector with a zero-latency combinational
// output and a one-cycle registered copy.
//
// Ports:
//   clk        - rising-edge clock (registered path only)
//   rst        - synchronous active-high reset of y_q / y_q_valid
//   a, b       - WIDTH-bit operands (sel = 0 -> a, sel = 1 -> b)
//   sel        - select; anything other than a clean 1 picks a
//   in_valid   - qualifies a/b/sel for the registered path
//   y          - combinational result, independent of clk/rst/in_valid
//   y_q        - result captured on the last in_valid edge
//   y_q_valid  - high the cycle after an in_valid capture
//
// Handshake: in_valid is a valid-only qualifier with no ready/backpressure;
// each edge with in_valid = 1 produces one result on y_q one cycle later.
module mux2x1_core
  import mux_pkg::*;
#(
  parameter int                       WIDTH     = MUX_DEFAULT_WIDTH,
  parameter logic [MUX_MAX_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             y_q_valid
);

  // The registered path captures the very same selection as y, so the two
  // outputs can never disagree about which operand was chosen.
  assign y = WIDTH'(mux_sel(MUX_MAX_WIDTH'(a), MUX_MAX_WIDTH'(b), sel));

  mux2x1_oreg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_oreg (
    .clk     (clk),
    .rst     (rst),
    .load    (in_valid),
    .d       (y),
    .q       (y_q),
    .q_valid (y_q_valid)
  );

endmodule : mux2x1_core

// File: tb/tb_mux2x1_core.sv
module tb_mux2x1_core;

  localparam logic [63:0] RV64 = 64'h0000_1234_5678_9ABC;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  logic       a1, b1, sel1, v1;
  logic       y1, yq1, yqv1;
  logic [7:0] a8, b8, y8, yq8;
  logic       sel8, v8, yqv8;
  logic [63:0] a64, b64, y64, yq64;
  logic        sel64, v64, yqv64;

  mux2x1_core #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .sel(sel1), .in_valid(v1),
    .y(y1), .y_q(yq1), .y_q_valid(yqv1)
  );

  mux2x1_core #(.WIDTH(8), .RESET_VAL(64'h0)) u_w8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .sel(sel8), .in_valid(v8),
    .y(y8), .y_q(yq8), .y_q_valid(yqv8)
  );

  mux2x1_core #(.WIDTH(64), .RESET_VAL(RV64)) u_w64 (
    .clk(clk), .rst(rst), .a(a64), .b(b64), .sel(sel64), .in_valid(v64),
    .y(y64), .y_q(yq64), .y_q_valid(yqv64)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0]  exp_q[$];
  logic [63:0] exp64_q[$];
  logic [7:0]  last_q8;
  logic        exp_v8;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive the W8 DUT at the falling edge; record what the next edge must
  // produce on the registered path.
  task automatic drive8(input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic v);
    @(negedge clk);
    a8 = a; b8 = b; sel8 = s; v8 = v;
    #1;
    check("w8_y_live", y8, (s === 1'b1) ? b : a);
    exp_v8 = v && !rst;
    if (exp_v8) exp_q.push_back((s === 1'b1) ? b : a);
  endtask

  task automatic edge8(input string name);
    logic [7:0] e;
    @(posedge clk);
    #1;
    check({name, "_valid"}, yqv8, exp_v8);
    if (exp_v8) begin
      if (exp_q.size() == 0) begin
        check({name, "_queue_empty"}, 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        last_q8 = e;
      end
    end
    check({name, "_yq"}, yq8, last_q8);
  endtask

  // ---------------- vector tables ----------------
  typedef struct { logic a; logic b; logic sel; logic exp_y; } vec1_t;
  typedef struct { logic [7:0] a; logic [7:0] b; logic sel; } vec8_t;
  vec1_t t1[6];
  vec8_t t8[3];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  e8;
    logic [63:0] prev_y;
    a1 = 0; b1 = 0; sel1 = 0; v1 = 0;
    a8 = 0; b8 = 0; sel8 = 0; v8 = 0;
    a64 = 0; b64 = 0; sel64 = 0; v64 = 0;
    last_q8 = 8'h00; exp_v8 = 1'b0;

    t1[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    t1[1] = '{1'b1, 1'b0, 1'b0, 1'b1};
    t1[2] = '{1'b0, 1'b1, 1'b1, 1'b1};
    t1[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
    t1[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    t1[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
    t8[0] = '{8'hA5, 8'h3C, 1'b0};
    t8[1] = '{8'hA5, 8'h3C, 1'b1};
    t8[2] = '{8'hA5, 8'h3C, 1'bx};

    // Combinational truth table, WIDTH = 1 (reset held throughout).
    for (int i = 0; i < 6; i++) begin
      a1 = t1[i].a; b1 = t1[i].b; sel1 = t1[i].sel;
      #10;
      check($sformatf("w1_tt%0d", i), y1, t1[i].exp_y);
    end

    // Reset state after several edges with rst high.
    @(posedge clk); #1;
    check("rst_w8_yq", yq8, 64'h0);
    check("rst_w8_valid", yqv8, 1'b0);
    check("rst_w64_yq", yq64, RV64);
    check("rst_w64_valid", yqv64, 1'b0);
    check("rst_w1_valid", yqv1, 1'b0);

    // WIDTH = 8 sweep including an unknown select.
    for (int i = 0; i < 3; i++) begin
      a8 = t8[i].a; b8 = t8[i].b; sel8 = t8[i].sel;
      #10;
      e8 = (sel8 === 1'b1) ? t8[i].b : t8[i].a;
      check($sformatf("w8_sweep%0d", i), y8, e8);
    end
    // y ignores in_valid and rst.
    v8 = 1'b1; #1;
    check("w8_y_indep_valid", y8, e8);
    v8 = 1'b0;

    @(negedge clk);
    rst = 1'b0;

    // Registered latency.
    drive8(8'h00, 8'h3C, 1'b1, 1'b1); edge8("lat_e1");
    drive8(8'hA5, 8'h00, 1'b0, 1'b1); edge8("lat_e2");

    // Hold: capture 3C, then three idle cycles with moving inputs.
    drive8(8'h11, 8'h3C, 1'b1, 1'b1); edge8("hold_cap");
    for (int i = 0; i < 3; i++) begin
      drive8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), 1'b0);
      edge8($sformatf("hold%0d", i));
    end
    check("hold_final", yq8, 8'h3C);

    // Reset mid-stream has priority over in_valid.
    @(negedge clk);
    rst = 1'b1; a8 = 8'h00; b8 = 8'hFF; sel8 = 1'b1; v8 = 1'b1;
    @(posedge clk); #1;
    check("midrst_yq", yq8, 8'h00);
    check("midrst_valid", yqv8, 1'b0);
    last_q8 = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    v8 = 1'b0;
    exp_v8 = 1'b0;
    edge8("post_rst_idle");
    drive8(8'h5A, 8'hFF, 1'b1, 1'b1); edge8("post_rst_cap");

    // Random stream through the scoreboard.
    for (int i = 0; i < 20; i++) begin
      drive8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      edge8($sformatf("rand%0d", i));
    end
    check("rand_queue_drained", 64'(exp_q.size()), 64'd0);

    // WIDTH = 64: y alternates, y_q lags by one cycle.
    a64 = '1; b64 = '0; v64 = 1'b1; sel64 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sel64 = ~sel64;
      #1;
      prev_y = sel64 ? 64'h0 : '1;
      check($sformatf("w64_y%0d", i), y64, prev_y);
      exp64_q.push_back(prev_y);
      @(posedge clk); #1;
      check($sformatf("w64_yq%0d", i), yq64, exp64_q.pop_front());
      check($sformatf("w64_v%0d", i), yqv64, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_mux2x1_core
